// File: rtl/vu_bar_renderer.sv
// VU meter overlay: captures audio levels, updates a bar and a decaying peak
// marker once per frame, and paints them into a registered RGB pixel stream.
module vu_bar_renderer #(
    parameter int V_POL       = 0,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY       = 2,
    parameter int BAR_TOP     = 200,
    parameter int BAR_H       = 80
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [7:0] level_in,
    input  logic       level_valid,
    input  logic       disp_enable,
    input  logic [9:0] row,
    input  logic [9:0] column,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       h_sync_out,
    output logic       v_sync_out
);

    localparam int          HW       = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] LP_HOLD = HW'(HOLD_FRAMES);
    localparam logic [8:0]  LP_DEC   = 9'(DECAY);
    localparam logic        LP_ACT   = (V_POL != 0);
    localparam logic [9:0]  LP_TOP   = 10'(BAR_TOP);
    localparam logic [9:0]  LP_BOT   = 10'(BAR_TOP + BAR_H - 1);

    logic [7:0]    r_pending;
    logic [7:0]    r_shown;
    logic [7:0]    r_peak;
    logic [HW-1:0] r_hold;
    logic          r_vsync;
    logic          r_armed;
    logic [3:0]    r_red, r_green, r_blue;
    logic          r_hs_out, r_vs_out;

    logic          w_tick;
    logic [8:0]    w_dec;
    logic [7:0]    w_floor;
    logic [7:0]    w_decayed;
    logic [9:0]    w_fill_lim;
    logic [9:0]    w_pk_lo;
    logic [9:0]    w_pk_hi;
    logic          w_in_bar;
    logic          w_lit;
    logic          w_marker;

    // r_armed keeps the reset value of r_vsync from faking an edge: a tick
    // needs v_sync to have been seen inactive at least once after reset.
    assign w_tick = (v_sync == LP_ACT) && (r_vsync != LP_ACT) && r_armed;

    // 9-bit subtract so a peak below DECAY clamps at zero instead of wrapping
    assign w_dec     = {1'b0, r_peak} - LP_DEC;
    assign w_floor   = ({1'b0, r_peak} < LP_DEC) ? 8'd0 : w_dec[7:0];
    assign w_decayed = (w_floor < r_pending) ? r_pending : w_floor;

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_vsync <= ~LP_ACT;
            r_armed <= 1'b0;
        end else begin
            r_vsync <= v_sync;
            if (v_sync != LP_ACT)
                r_armed <= 1'b1;
        end
    end

    // shown/peak/hold move only on the frame tick; a coincident strobe
    // lands in pending and is displayed on the following frame
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_shown   <= '0;
            r_peak    <= '0;
            r_hold    <= '0;
        end else begin
            if (level_valid)
                r_pending <= level_in;
            if (w_tick) begin
                r_shown <= r_pending;
                if (r_pending >= r_peak) begin
                    r_peak <= r_pending;
                    r_hold <= LP_HOLD;
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end else begin
                    r_peak <= w_decayed;
                end
            end
        end
    end

    assign w_fill_lim = {1'b0, r_shown, 1'b0};
    assign w_pk_lo    = {1'b0, r_peak, 1'b0};
    assign w_pk_hi    = w_pk_lo + 10'd3;
    assign w_in_bar   = disp_enable && (row >= LP_TOP) && (row <= LP_BOT);
    assign w_lit      = w_in_bar && (column < w_fill_lim);
    assign w_marker   = w_in_bar && (r_peak != 8'd0) &&
                        (column >= w_pk_lo) && (column <= w_pk_hi);

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_hs_out <= ~LP_ACT;
            r_vs_out <= ~LP_ACT;
        end else begin
            r_hs_out <= h_sync;
            r_vs_out <= v_sync;
            if (w_marker) begin
                r_red   <= 4'hF;
                r_green <= 4'hF;
                r_blue  <= 4'hF;
            end else if (w_lit) begin
                r_red   <= (column >= 10'd320) ? 4'hF : 4'h0;
                r_green <= (column < 10'd448)  ? 4'hF : 4'h0;
                r_blue  <= 4'h0;
            end else begin
                r_red   <= 4'h0;
                r_green <= 4'h0;
                r_blue  <= 4'h0;
            end
        end
    end

    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;
    assign h_sync_out = r_hs_out;
    assign v_sync_out = r_vs_out;

endmodule

// File: tb/tb_vu_bar_renderer.sv
// Directed bench for vu_bar_renderer with default parameters (V_POL=0,
// HOLD 30, DECAY 2, bar rows 200..279).
module tb_vu_bar_renderer;

    logic       pixel_clock = 1'b0;
    logic       reset       = 1'b0;
    logic [7:0] level_in    = '0;
    logic       level_valid = 1'b0;
    logic       disp_enable = 1'b0;
    logic [9:0] row         = '0;
    logic [9:0] column      = '0;
    logic       h_sync      = 1'b1;
    logic       v_sync      = 1'b1;
    logic [3:0] red, green, blue;
    logic       h_sync_out, v_sync_out;

    int n_checks = 0;
    int n_fail   = 0;

    vu_bar_renderer dut (
        .pixel_clock(pixel_clock), .reset(reset),
        .level_in(level_in), .level_valid(level_valid),
        .disp_enable(disp_enable), .row(row), .column(column),
        .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic step();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic px(input int r, input int c, input logic de);
        row         = 10'(r);
        column      = 10'(c);
        disp_enable = de;
        step();
    endtask

    task automatic strobe(input logic [7:0] v);
        level_in    = v;
        level_valid = 1'b1;
        step();
        level_valid = 1'b0;
    endtask

    task automatic tick();
        v_sync = 1'b1; step();
        v_sync = 1'b0; step();
        v_sync = 1'b1; step();
    endtask

    task automatic do_reset();
        reset = 1'b0; v_sync = 1'b1; step();
        reset = 1'b1; step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        disp_enable = 1'b1; row = 10'd210; column = 10'd10;
        for (int i = 0; i < 6; i++) begin
            level_in = 8'd200; level_valid = 1'b1;
            v_sync = i[0]; h_sync = ~i[0];
            step();
            n_checks++;
            if ({red, green, blue} !== 12'h000 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d got rgb=%h hs=%b vs=%b exp rgb=000 hs=1 vs=1",
                         i, {red, green, blue}, h_sync_out, v_sync_out);
            end
        end
        level_valid = 1'b0; v_sync = 1'b1; h_sync = 1'b1;
        reset = 1'b1; step();
        tick();
        px(210, 10, 1'b1);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_first_tick got %h exp 000", {red, green, blue});
        end
        strobe(8'd100);
        tick();
        px(210, 10, 1'b1);
        n_checks++;
        if ({red, green, blue} !== 12'h0F0) begin
            n_fail++;
            $display("FAIL reset_second_tick got %h exp 0f0", {red, green, blue});
        end
    endtask

    task automatic test_level100();
        int r[8]          = '{210, 210, 210, 210, 210, 200, 199, 280};
        int c[8]          = '{0, 199, 200, 203, 204, 100, 100, 100};
        logic [11:0] e[8] = '{12'h0F0, 12'h0F0, 12'hFFF, 12'hFFF, 12'h000, 12'h0F0, 12'h000, 12'h000};
        do_reset();
        strobe(8'd100);
        tick();
        for (int i = 0; i < 8; i++) begin
            px(r[i], c[i], 1'b1);
            n_checks++;
            if ({red, green, blue} !== e[i]) begin
                n_fail++;
                $display("FAIL level100 row %0d col %0d got %h exp %h", r[i], c[i], {red, green, blue}, e[i]);
            end
        end
    endtask

    task automatic test_level255();
        int c[10]          = '{0, 319, 320, 447, 448, 509, 510, 513, 514, 600};
        logic [11:0] e[10] = '{12'h0F0, 12'h0F0, 12'hFF0, 12'hFF0, 12'hF00,
                               12'hF00, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
        do_reset();
        strobe(8'd255);
        tick();
        for (int i = 0; i < 10; i++) begin
            px(250, c[i], 1'b1);
            n_checks++;
            if ({red, green, blue} !== e[i]) begin
                n_fail++;
                $display("FAIL level255 col %0d got %h exp %h", c[i], {red, green, blue}, e[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            px(250, c[i], 1'b0);
            n_checks++;
            if ({red, green, blue} !== 12'h000) begin
                n_fail++;
                $display("FAIL level255_de0 col %0d got %h exp 000", c[i], {red, green, blue});
            end
        end
    endtask

    task automatic test_peak_decay();
        int exp_pk;
        do_reset();
        strobe(8'd200);
        tick();
        px(250, 400, 1'b1);
        n_checks++;
        if ({red, green, blue} !== 12'hFFF) begin
            n_fail++;
            $display("FAIL peak_initial got %h exp fff", {red, green, blue});
        end
        strobe(8'd0);
        for (int k = 2; k <= 133; k++) begin
            tick();
            exp_pk = (k <= 31) ? 200 : ((200 - 2 * (k - 31)) > 0 ? 200 - 2 * (k - 31) : 0);
            px(250, 2 * exp_pk, 1'b1);
            n_checks++;
            if ({red, green, blue} !== ((exp_pk != 0) ? 12'hFFF : 12'h000)) begin
                n_fail++;
                $display("FAIL peak_decay tick %0d col %0d got %h exp_peak %0d", k, 2 * exp_pk, {red, green, blue}, exp_pk);
            end
            if (exp_pk != 0) begin
                px(250, 2 * exp_pk - 1, 1'b1);
                n_checks++;
                if ({red, green, blue} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL peak_below tick %0d got %h exp 000", k, {red, green, blue});
                end
            end
        end
    endtask

    task automatic test_coincident();
        int c[5]          = '{158, 160, 164, 98, 100};
        logic [11:0] e1[5] = '{12'h0F0, 12'hFFF, 12'h000, 12'h0F0, 12'h0F0};
        logic [11:0] e2[5] = '{12'h000, 12'hFFF, 12'h000, 12'h0F0, 12'h000};
        do_reset();
        strobe(8'd80);
        v_sync = 1'b1; step();
        v_sync = 1'b0; level_in = 8'd50; level_valid = 1'b1; step();
        v_sync = 1'b1; level_valid = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            px(220, c[i], 1'b1);
            n_checks++;
            if ({red, green, blue} !== e1[i]) begin
                n_fail++;
                $display("FAIL coincident_f1 col %0d got %h exp %h", c[i], {red, green, blue}, e1[i]);
            end
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            px(220, c[i], 1'b1);
            n_checks++;
            if ({red, green, blue} !== e2[i]) begin
                n_fail++;
                $display("FAIL coincident_f2 col %0d got %h exp %h", c[i], {red, green, blue}, e2[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic hs_pat[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic vs_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        strobe(8'd100);
        tick();
        for (int i = 0; i < 6; i++) begin
            h_sync = hs_pat[i]; v_sync = vs_pat[i];
            step();
            n_checks++;
            if (h_sync_out !== hs_pat[i] || v_sync_out !== vs_pat[i]) begin
                n_fail++;
                $display("FAIL sync_delay cyc %0d got hs=%b vs=%b exp hs=%b vs=%b",
                         i, h_sync_out, v_sync_out, hs_pat[i], vs_pat[i]);
            end
        end
        h_sync = 1'b1; v_sync = 1'b1;
        px(230, 199, 1'b1);
        column = 10'd204;
        #2;
        n_checks++;
        if ({red, green, blue} !== 12'h0F0) begin
            n_fail++;
            $display("FAIL rgb_no_comb got %h exp 0f0", {red, green, blue});
        end
        step();
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL rgb_one_cycle got %h exp 000", {red, green, blue});
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        strobe(8'd255);
        tick();
        px(240, 100, 1'b1);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({red, green, blue} !== 12'h000 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midframe got rgb=%h hs=%b vs=%b exp 000 1 1", {red, green, blue}, h_sync_out, v_sync_out);
        end
        reset = 1'b1; step();
        px(240, 100, 1'b1);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_midframe_after got %h exp 000", {red, green, blue});
        end
    endtask

    initial begin
        test_reset();
        test_level100();
        test_level255();
        test_peak_decay();
        test_coincident();
        test_latency();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
